i2c_req_arbiter: RTL and testbench

- Shares one I2C_Master transaction engine between NUM_REQ on-chip requesters, e.g. a sensor poller, a config loader and a debug port.
- Grants round-robin, issues one complete register transaction (device address, register address, data, RW) per grant, waits for engine completion, and returns a tagged response to the winner.
- Guards against a hung bus with a completion timeout.

---
 rtl/i2c_req_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
//   Shares one I2C master transaction engine between NUM_REQ requesters.
//   Round-robin grant, one register transaction per grant, completion
//   timeout with engine abort, tagged response back to the winner.
//
//   Optional feature macro: I2C_ARB_RETRY_EN
//     defined   : a NACKed transaction is re-issued up to MAX_RETRY times
//                 before the NACK is reported.
//     undefined : a NACK is reported immediately, no retry counter exists.
//
// Ports
//   clk, rst          system clock, async active-high reset
//   req_valid/_ready  per-requester handshake (ready = one-cycle consume)
//   req_dev_addr      flattened 7-bit device addresses, lane i at [7i+6:7i]
//   req_reg_addr      flattened 8-bit register addresses
//   req_data          flattened 8-bit write data
//   req_rw            per-requester 1 = read, 0 = write
//   m_start           one-cycle launch pulse to the engine
//   m_dev_addr/_reg_addr/_data/_rw  registered transaction fields
//   m_abort           one-cycle pulse forcing the engine to STOP/IDLE
//   m_busy            engine not idle (blocks new grants)
//   m_done/m_nack/m_rd_data  engine completion and result
//   rsp_valid/_id/_data/_err response pulse (err 00 OK, 01 NACK, 10 timeout)
// ---------------------------------------------------------------------------
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*7-1:0] req_dev_addr,
    input  logic [NUM_REQ*8-1:0] req_reg_addr,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_rw,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 m_start,
    output logic [6:0]           m_dev_addr,
    output logic [7:0]           m_reg_addr,
    output logic [7:0]           m_data,
    output logic                 m_rw,
    output logic                 m_abort,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_rd_data,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_data,
    output logic [1:0]           rsp_err
);
    localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_REQ > (1 << ID_W) ||
        TIMEOUT_CYCLES < 2 || MAX_RETRY < 0) begin : g_bad_params
        $error("i2c_req_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RESP} state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic                r_m_start;
    logic [6:0]          r_m_dev_addr;
    logic [7:0]          r_m_reg_addr;
    logic [7:0]          r_m_data;
    logic                r_m_rw;
    logic                r_m_abort;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [7:0]          r_rsp_data;
    logic [1:0]          r_rsp_err;

    // Round-robin pick: first valid lane searching upward from last_grant+1.
    // The offset k walks 1..NUM_REQ; lane i matches offset k either directly
    // or after wrap-around, so no modulo hardware is needed.
    logic                w_found;
    logic [ID_W-1:0]     w_sel;
    logic [6:0]          w_sel_dev;
    logic [7:0]          w_sel_reg;
    logic [7:0]          w_sel_dat;
    logic                w_sel_rw;

    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_sel_dev = '0;
        w_sel_reg = '0;
        w_sel_dat = '0;
        w_sel_rw  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] &&
                    ((int'(r_last_grant) + k == i) ||
                     (int'(r_last_grant) + k == i + NUM_REQ))) begin
                    w_found   = 1'b1;
                    w_sel     = ID_W'(i);
                    w_sel_dev = req_dev_addr[7*i +: 7];
                    w_sel_reg = req_reg_addr[8*i +: 8];
                    w_sel_dat = req_data[8*i +: 8];
                    w_sel_rw  = req_rw[i];
                end
            end
        end
    end

    logic w_retry;
`ifdef I2C_ARB_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0] r_retry_cnt;
    assign w_retry = m_nack && (int'(r_retry_cnt) < MAX_RETRY);
`else
    assign w_retry = 1'b0;
`endif

    // r_cnt holds the number of cycles elapsed since the current m_start.
    // The abort decision is taken when it will read TIMEOUT_CYCLES-1 on the
    // next cycle, so m_abort and that count become visible together. An
    // m_done in the decision cycle takes priority; the following abort
    // cycle ignores the engine and goes straight to the timeout response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_cnt        <= '0;
            r_req_ready  <= '0;
            r_m_start    <= 1'b0;
            r_m_dev_addr <= '0;
            r_m_reg_addr <= '0;
            r_m_data     <= '0;
            r_m_rw       <= 1'b0;
            r_m_abort    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= '0;
`ifdef I2C_ARB_RETRY_EN
            r_retry_cnt  <= '0;
`endif
        end else begin
            r_req_ready <= '0;
            r_m_start   <= 1'b0;
            r_m_abort   <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !m_busy) begin
                        r_grant_id   <= w_sel;
                        r_m_dev_addr <= w_sel_dev;
                        r_m_reg_addr <= w_sel_reg;
                        r_m_data     <= w_sel_dat;
                        r_m_rw       <= w_sel_rw;
                        r_cnt        <= '0;
                        r_m_start    <= 1'b1;
                        r_req_ready  <= NUM_REQ'(1) << w_sel;
`ifdef I2C_ARB_RETRY_EN
                        r_retry_cnt  <= '0;
`endif
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (r_m_abort) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_grant_id;
                        r_rsp_data  <= 8'h00;
                        r_rsp_err   <= ERR_TMO;
                        r_state     <= S_RESP;
                    end else if (m_done && w_retry) begin
                        // Re-issue the latched fields; the requester was
                        // already consumed, so no req_ready this time.
`ifdef I2C_ARB_RETRY_EN
                        r_retry_cnt <= r_retry_cnt + 1'b1;
`endif
                        r_cnt       <= '0;
                        r_m_start   <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else if (m_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_grant_id;
                        r_rsp_err   <= m_nack ? ERR_NACK : ERR_OK;
                        r_rsp_data  <= (r_m_rw && !m_nack) ? m_rd_data : 8'h00;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2))
                            r_m_abort <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_grant_id;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign m_start    = r_m_start;
    assign m_dev_addr = r_m_dev_addr;
    assign m_reg_addr = r_m_reg_addr;
    assign m_data     = r_m_data;
    assign m_rw       = r_m_rw;
    assign m_abort    = r_m_abort;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_req_arbiter
//   Directed + randomized bench for i2c_req_arbiter. A behavioural engine
//   answers m_start after a programmable delay; expectations come from a
//   transaction-level model (round-robin pick, error/data rules, latency
//   arithmetic).
// ---------------------------------------------------------------------------
module tb_i2c_req_arbiter;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int TMO = 100;
    localparam int MR  = 2;
`ifdef I2C_ARB_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*7-1:0] req_dev_addr;
    logic [NR*8-1:0] req_reg_addr;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_rw;
    logic [NR-1:0]   req_ready;
    logic            m_start;
    logic [6:0]      m_dev_addr;
    logic [7:0]      m_reg_addr;
    logic [7:0]      m_data;
    logic            m_rw;
    logic            m_abort;
    logic            m_busy;
    logic            m_done;
    logic            m_nack;
    logic [7:0]      m_rd_data;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [7:0]      rsp_data;
    logic [1:0]      rsp_err;

    i2c_req_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
        .req_data(req_data), .req_rw(req_rw), .req_ready(req_ready),
        .m_start(m_start), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr),
        .m_data(m_data), .m_rw(m_rw), .m_abort(m_abort),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rd_data(m_rd_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // requester-side transaction fields
    logic [6:0] t_dev [NR];
    logic [7:0] t_reg [NR];
    logic [7:0] t_dat [NR];
    logic       t_rw  [NR];

    // engine behaviour knobs
    int         eng_dly  = 1;
    logic       eng_nack = 1'b0;
    logic [7:0] eng_rd   = 8'h00;
    logic       eng_hang = 1'b0;
    int         eng_cnt  = 0;

    // model state: last requester answered
    int mdl_last = NR - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({req_ready, m_start, m_dev_addr, m_reg_addr, m_data, m_rw,
                    m_abort, rsp_valid, rsp_id, rsp_data, rsp_err});
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] mask, input int last);
        logic [NR-1:0] sh;
        for (int k = 1; k <= NR; k++) begin
            sh = mask >> ((last + k) % NR);
            if (sh[0]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive_reqs(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) begin
            req_dev_addr[7*i +: 7] = t_dev[i];
            req_reg_addr[8*i +: 8] = t_reg[i];
            req_data[8*i +: 8]     = t_dat[i];
            req_rw[i]              = t_rw[i];
        end
        req_valid = mask;
    endtask

    task automatic rand_lane(input int i);
        t_dev[i] = 7'($urandom);
        t_reg[i] = 8'($urandom);
        t_dat[i] = 8'($urandom);
        t_rw[i]  = 1'($urandom);
    endtask

    // Engine: answers m_start eng_dly cycles later with m_done, or never when
    // hanging; m_abort or reset drops it back to idle.
    initial begin
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            m_done = 1'b0; m_nack = 1'b0; m_rd_data = 8'h00;
            if (rst) begin
                eng_cnt = 0; m_busy = 1'b0;
            end else if (m_abort) begin
                eng_cnt = 0; m_busy = 1'b0;
            end else if (m_start) begin
                eng_cnt = eng_dly; m_busy = 1'b1;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && !eng_hang) begin
                    m_done = 1'b1; m_nack = eng_nack; m_rd_data = eng_rd; m_busy = 1'b0;
                end
            end
        end
    end

    // One arbitration round: present 'mask', run to the response, check it.
    task automatic run_txn(input string nm, input logic [NR-1:0] mask, input int dly,
                           input logic nk, input logic [7:0] rd, input logic hang);
        int win, t_drive, first_start, n_start, n_ready, ready_idx, n_abort, abort_cyc, rsp_cyc;
        int exp_starts, exp_lat;
        logic tmo, got_rsp;
        logic [1:0]  exp_err;
        logic [7:0]  exp_data;
        logic [23:0] e_fields, s_fields, h_fields;
        logic [IDW-1:0] r_id;
        logic [7:0]  r_data;
        logic [1:0]  r_err;

        win        = rr_pick(mask, mdl_last);
        e_fields   = {t_dev[win], t_reg[win], t_dat[win], t_rw[win]};
        tmo        = hang || (dly > TMO - 2);
        exp_starts = (!tmo && nk && RETRY_ON) ? MR + 1 : 1;
        exp_lat    = tmo ? TMO : exp_starts * (dly + 1);
        exp_err    = tmo ? 2'b10 : (nk ? 2'b01 : 2'b00);
        exp_data   = (!tmo && !nk && t_rw[win]) ? rd : 8'h00;

        eng_dly = dly; eng_nack = nk; eng_rd = rd; eng_hang = hang;
        first_start = -1; n_start = 0; n_ready = 0; ready_idx = -1;
        n_abort = 0; abort_cyc = -1; rsp_cyc = -1; got_rsp = 1'b0;
        s_fields = '0; h_fields = '0; r_id = '0; r_data = '0; r_err = '0;

        @(negedge clk);
        drive_reqs(mask);
        t_drive = cyc;
        for (int b = 0; b < 3 * TMO + 200 && !got_rsp; b++) begin
            @(negedge clk);
            if (m_start || m_abort || rsp_valid || (|req_ready))
                chk({nm, ".pulse_excl"},
                    64'({rsp_valid && (m_start || m_abort || (|req_ready)),
                         m_abort && (m_start || (|req_ready)),
                         (|req_ready) && !m_start}), 64'd0);
            if (m_start) begin
                if (n_start == 0) begin
                    first_start = cyc;
                    s_fields = {m_dev_addr, m_reg_addr, m_data, m_rw};
                end
                n_start++;
            end
            if (|req_ready) begin
                n_ready++;
                chk({nm, ".ready_onehot"}, 64'($countones(req_ready)), 64'd1);
                for (int i = 0; i < NR; i++) if (req_ready[i]) ready_idx = i;
                // consumed: withdraw and scramble that lane to prove latching
                rand_lane(ready_idx);
                drive_reqs(req_valid & ~(NR'(1) << ready_idx));
            end
            if (m_abort) begin
                n_abort++; abort_cyc = cyc;
            end
            if (rsp_valid) begin
                got_rsp = 1'b1; rsp_cyc = cyc;
                r_id = rsp_id; r_data = rsp_data; r_err = rsp_err;
                h_fields = {m_dev_addr, m_reg_addr, m_data, m_rw};
            end
        end
        req_valid = '0;

        chk({nm, ".rsp_seen"},    64'(got_rsp), 64'd1);
        chk({nm, ".ready_idx"},   64'(ready_idx), 64'(win));
        chk({nm, ".ready_cnt"},   64'(n_ready), 64'd1);
        chk({nm, ".start_lat"},   64'(first_start - t_drive), 64'd1);
        chk({nm, ".start_cnt"},   64'(n_start), 64'(exp_starts));
        chk({nm, ".m_fields"},    64'(s_fields), 64'(e_fields));
        chk({nm, ".m_hold"},      64'(h_fields), 64'(e_fields));
        chk({nm, ".abort_cnt"},   64'(n_abort), 64'(tmo ? 1 : 0));
        chk({nm, ".abort_at"},    64'(n_abort > 0 ? abort_cyc - first_start : -1),
                                  64'(tmo ? TMO - 1 : -1));
        chk({nm, ".rsp_lat"},     64'(rsp_cyc - first_start), 64'(exp_lat));
        chk({nm, ".rsp_id"},      64'(r_id), 64'(win));
        chk({nm, ".rsp_err"},     64'(r_err), 64'(exp_err));
        chk({nm, ".rsp_data"},    64'(r_data), 64'(exp_data));
        mdl_last = win;
    endtask

    initial begin
        logic saw;
        rst = 1'b1;
        req_valid = '0; req_dev_addr = '0; req_reg_addr = '0; req_data = '0; req_rw = '0;
        for (int i = 0; i < NR; i++) rand_lane(i);

        // reset state
        @(negedge clk);
        chk("reset_outs", outs_vec(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl_last = NR - 1;

        // single write from requester 2, read data must be suppressed
        t_dev[2] = 7'h50; t_reg[2] = 8'h10; t_dat[2] = 8'hA5; t_rw[2] = 1'b0;
        run_txn("write", 4'b0100, 20, 1'b0, 8'h77, 1'b0);

        // read from requester 1
        t_rw[1] = 1'b1;
        run_txn("read", 4'b0010, 12, 1'b0, 8'h3C, 1'b0);

        // leave last grant at 0, then reset in the middle of a transaction
        run_txn("pre_rst", 4'b0001, 5, 1'b0, 8'h11, 1'b0);
        rand_lane(2);
        eng_dly = 40; eng_hang = 1'b0; eng_nack = 1'b0;
        @(negedge clk);
        drive_reqs(4'b0100);
        for (int k = 0; k < 20 && !m_start; k++) @(negedge clk);
        chk("rst_inflight_start", 64'(m_start), 64'd1);
        req_valid = '0;
        repeat (5) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1 chk("rst_async_zero", outs_vec(), 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        mdl_last = NR - 1;
        saw = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (rsp_valid || m_start) saw = 1'b1;
        end
        chk("rst_no_rsp", 64'(saw), 64'd0);

        // round-robin with everyone requesting: 0,1,2,3,0
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NR; i++) rand_lane(i);
            run_txn("rr", 4'hF, 3 + r, 1'b0, 8'h5A, 1'b0);
        end

        // timeout on requester 1, next grant goes to requester 2
        for (int i = 0; i < NR; i++) rand_lane(i);
        run_txn("timeout", 4'b0010, 5, 1'b0, 8'h00, 1'b1);
        run_txn("after_tmo", 4'hF, 8, 1'b0, 8'h42, 1'b0);

        // m_done in the expiry decision cycle wins; one cycle later is too late
        t_rw[3] = 1'b1;
        run_txn("done_at_edge", 4'b1000, TMO - 2, 1'b0, 8'hC3, 1'b0);
        run_txn("done_late", 4'b1000, TMO - 1, 1'b0, 8'hC3, 1'b0);

        // persistent NACK
        t_rw[0] = 1'b1;
        run_txn("nack", 4'b0001, 7, 1'b1, 8'h99, 1'b0);

        // randomized traffic
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NR; i++) rand_lane(i);
            run_txn("rand", NR'($urandom_range(1, 15)), $urandom_range(1, 30),
                    1'($urandom_range(0, 5) == 0), 8'($urandom),
                    1'($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
